// File: rtl/calc_ctrl_fsm.sv
// Calculator sequencing controller: builds operands from key events, runs one
// start/done ALU transaction on "=", and holds the result or an error for display.
module calc_ctrl_fsm #(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned W       = 14,
  parameter int unsigned RES_W   = 28,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_press,
  input  logic             is_num,
  input  logic             is_op,
  input  logic             is_eq,
  input  logic [3:0]       num_val,
  input  logic [1:0]       op_val,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [1:0]       alu_op,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [RES_W-1:0] alu_result,
  input  logic             alu_err,
  output logic [RES_W-1:0] disp_val,
  output logic             err,
  output logic             busy
);

  localparam int unsigned CW      = $clog2(DIGITS + 1);
  localparam int unsigned TW      = $clog2(TIMEOUT + 1);
  localparam int unsigned MAX_VAL = 10 ** DIGITS - 1;

  typedef enum logic [2:0] {S_A, S_OP, S_B, S_EXEC, S_RES, S_ERR} state_e;

  state_e           state_q, state_d;
  logic             btn_q;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             start_q, start_d;
  logic [TW-1:0]    wait_q, wait_d;
  logic [RES_W-1:0] disp_q, disp_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic             key_evt_c;
  logic             is_clr_c;
  logic             res_ok_c;
  logic             cnt_room_c;
  logic [W-1:0]     a_app_c, b_app_c, dig_c;

  // x*10 + d without a multiplier
  function automatic logic [W-1:0] append_digit(input logic [W-1:0] x, input logic [W-1:0] d);
    return (x << 3) + (x << 1) + d;
  endfunction

  function automatic logic [RES_W-1:0] sext(input logic [W-1:0] x);
    return {{(RES_W - W){x[W-1]}}, x};
  endfunction

  assign key_evt_c  = btn_press & ~btn_q;
  assign is_clr_c   = ~(is_num | is_op | is_eq);
  assign res_ok_c   = ~disp_q[RES_W-1] && (disp_q <= RES_W'(MAX_VAL));
  assign cnt_room_c = (cnt_q < CW'(DIGITS));
  assign dig_c      = W'(num_val);
  assign a_app_c    = append_digit(a_q, dig_c);
  assign b_app_c    = append_digit(b_q, dig_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_A;
      btn_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      start_q <= 1'b0;
      wait_q  <= '0;
      disp_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q   <= btn_press;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      start_q <= start_d;
      wait_q  <= wait_d;
      disp_q  <= disp_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    start_d = 1'b0;
    wait_d  = wait_q;
    disp_d  = disp_q;
    err_d   = err_q;

    if (state_q == S_EXEC) begin
      // keys are discarded while the ALU owns the operands
      if (!start_q && alu_done) begin
        if (alu_err) begin
          err_d   = 1'b1;
          disp_d  = '0;
          state_d = S_ERR;
        end else begin
          disp_d  = alu_result;
          state_d = S_RES;
        end
      end else if (wait_q == TW'(TIMEOUT - 1)) begin
        err_d   = 1'b1;
        disp_d  = '0;
        state_d = S_ERR;
      end else begin
        wait_d = wait_q + TW'(1);
      end
    end else if (key_evt_c) begin
      if (is_clr_c) begin
        a_d     = '0;
        b_d     = '0;
        cnt_d   = '0;
        err_d   = 1'b0;
        disp_d  = '0;
        state_d = S_A;
      end else begin
        case (state_q)
          S_A: begin
            if (is_num) begin
              if (cnt_room_c) begin
                a_d    = a_app_c;
                cnt_d  = cnt_q + CW'(1);
                disp_d = sext(a_app_c);
              end
            end else if (is_op) begin
              op_d    = op_val;
              cnt_d   = '0;
              state_d = S_OP;
            end
          end
          S_OP: begin
            if (is_num) begin
              b_d     = dig_c;
              cnt_d   = CW'(1);
              disp_d  = sext(dig_c);
              state_d = S_B;
            end else if (is_op) begin
              op_d = op_val;
            end
          end
          S_B: begin
            if (is_num) begin
              if (cnt_room_c) begin
                b_d    = b_app_c;
                cnt_d  = cnt_q + CW'(1);
                disp_d = sext(b_app_c);
              end
            end else if (is_eq) begin
              start_d = 1'b1;
              wait_d  = '0;
              state_d = S_EXEC;
            end
          end
          S_RES: begin
            if (is_num) begin
              a_d     = dig_c;
              b_d     = '0;
              cnt_d   = CW'(1);
              disp_d  = sext(dig_c);
              state_d = S_A;
            end else if (is_op) begin
              // only a non-negative result that fits an operand can chain
              if (res_ok_c) begin
                a_d     = disp_q[W-1:0];
                op_d    = op_val;
                cnt_d   = '0;
                state_d = S_OP;
              end else begin
                err_d   = 1'b1;
                disp_d  = '0;
                state_d = S_ERR;
              end
            end
          end
          default: ;
        endcase
      end
    end

    busy_d = (state_d == S_EXEC);
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign alu_start = start_q;
  assign disp_val  = disp_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_calc_ctrl_fsm.sv
// Directed bench for calc_ctrl_fsm with a small latency-configurable ALU responder.
module tb_calc_ctrl_fsm;

  localparam int unsigned W       = 14;
  localparam int unsigned RES_W   = 28;
  localparam int unsigned TIMEOUT = 1023;

  logic             clk;
  logic             rst_n;
  logic             btn_press;
  logic             is_num;
  logic             is_op;
  logic             is_eq;
  logic [3:0]       num_val;
  logic [1:0]       op_val;
  logic [W-1:0]     alu_a;
  logic [W-1:0]     alu_b;
  logic [1:0]       alu_op;
  logic             alu_start;
  logic             alu_done;
  logic [RES_W-1:0] alu_result;
  logic             alu_err;
  logic [RES_W-1:0] disp_val;
  logic             err;
  logic             busy;

  int checks;
  int errors;

  // ALU responder configuration and observations
  int               cfg_lat;
  logic [RES_W-1:0] cfg_res;
  logic             cfg_err;
  int               pend;
  int               start_cnt;
  int               busy_cnt;
  logic [W-1:0]     cap_a;
  logic [W-1:0]     cap_b;
  logic [1:0]       cap_op;

  calc_ctrl_fsm #(.DIGITS(4), .W(W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_press  (btn_press),
    .is_num     (is_num),
    .is_op      (is_op),
    .is_eq      (is_eq),
    .num_val    (num_val),
    .op_val     (op_val),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .alu_err    (alu_err),
    .disp_val   (disp_val),
    .err        (err),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ALU responder: done pulses cfg_lat cycles after the start cycle (0 = never)
  initial begin
    alu_done   = 1'b0;
    alu_err    = 1'b0;
    alu_result = '0;
    pend       = 0;
    forever begin
      @(posedge clk);
      #1;
      alu_done = 1'b0;
      alu_err  = 1'b0;
      if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) begin
          alu_done   = 1'b1;
          alu_result = cfg_res;
          alu_err    = cfg_err;
        end
      end
      if (alu_start) begin
        start_cnt = start_cnt + 1;
        cap_a     = alu_a;
        cap_b     = alu_b;
        cap_op    = alu_op;
        if (cfg_lat > 0) pend = cfg_lat;
      end
      if (busy) busy_cnt = busy_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic n, input logic o, input logic e,
                     input logic [3:0] nv, input logic [1:0] ov, input int hold);
    is_num    = n;
    is_op     = o;
    is_eq     = e;
    num_val   = nv;
    op_val    = ov;
    btn_press = 1'b1;
    repeat (hold) tick();
    btn_press = 1'b0;
    is_num    = 1'b0;
    is_op     = 1'b0;
    is_eq     = 1'b0;
    tick();
  endtask

  task automatic dig(input logic [3:0] d);
    key(1'b1, 1'b0, 1'b0, d, 2'd0, 1);
  endtask

  task automatic opk(input logic [1:0] o);
    key(1'b0, 1'b1, 1'b0, 4'd0, o, 1);
  endtask

  task automatic eqk();
    key(1'b0, 1'b0, 1'b1, 4'd0, 2'd0, 1);
  endtask

  task automatic clr();
    key(1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      btn_press = 1'($urandom_range(0, 1));
      is_num    = 1'($urandom_range(0, 1));
      is_op     = 1'($urandom_range(0, 1));
      is_eq     = 1'($urandom_range(0, 1));
      num_val   = 4'($urandom_range(0, 9));
      op_val    = 2'($urandom_range(0, 3));
      tick();
    end
    checks++;
    if (disp_val !== '0 || err !== 1'b0 || busy !== 1'b0 || alu_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: disp=%0d err=%b busy=%b start=%b, expected 0/0/0/0",
               disp_val, err, busy, alu_start);
    end
    btn_press = 1'b0;
    is_num    = 1'b0;
    is_op     = 1'b0;
    is_eq     = 1'b0;
    rst_n     = 1'b1;
    tick();
    dig(4'd3);
    checks++;
    if (disp_val !== RES_W'(3) || alu_a !== W'(3)) begin
      errors++;
      $display("FAIL reset_first_key: disp=%0d a=%0d, expected 3/3", disp_val, alu_a);
    end
  endtask

  task automatic test_basic_add();
    clr();
    dig(4'd1); dig(4'd2); opk(2'd0); dig(4'd3);
    checks++;
    if (alu_a !== W'(12) || alu_b !== W'(3) || alu_op !== 2'd0 || disp_val !== RES_W'(3)) begin
      errors++;
      $display("FAIL add_operands: a=%0d b=%0d op=%0d disp=%0d, expected 12/3/0/3",
               alu_a, alu_b, alu_op, disp_val);
    end
    cfg_lat = 3; cfg_res = RES_W'(15); cfg_err = 1'b0;
    start_cnt = 0; busy_cnt = 0;
    eqk();
    repeat (8) tick();
    checks++;
    if (start_cnt !== 1 || cap_a !== W'(12) || cap_b !== W'(3) || cap_op !== 2'd0) begin
      errors++;
      $display("FAIL add_start: starts=%0d a=%0d b=%0d op=%0d, expected 1/12/3/0",
               start_cnt, cap_a, cap_b, cap_op);
    end
    checks++;
    if (busy_cnt !== 4) begin
      errors++;
      $display("FAIL add_busy_len: got %0d cycles, expected 4", busy_cnt);
    end
    checks++;
    if (disp_val !== RES_W'(15) || err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL add_result: disp=%0d err=%b busy=%b, expected 15/0/0", disp_val, err, busy);
    end
    eqk();
    checks++;
    if (disp_val !== RES_W'(15) || busy !== 1'b0) begin
      errors++;
      $display("FAIL res_eq_ignored: disp=%0d busy=%b, expected 15/0", disp_val, busy);
    end
    dig(4'd9);
    checks++;
    if (disp_val !== RES_W'(9) || alu_a !== W'(9) || alu_b !== W'(0)) begin
      errors++;
      $display("FAIL res_new_digit: disp=%0d a=%0d b=%0d, expected 9/9/0", disp_val, alu_a, alu_b);
    end
  endtask

  task automatic test_digit_limit();
    clr();
    dig(4'd1); dig(4'd2); dig(4'd3); dig(4'd4);
    key(1'b1, 1'b0, 1'b0, 4'd5, 2'd0, 20);
    checks++;
    if (disp_val !== RES_W'(1234) || alu_a !== W'(1234)) begin
      errors++;
      $display("FAIL digit_limit: disp=%0d a=%0d, expected 1234/1234", disp_val, alu_a);
    end
    start_cnt = 0;
    eqk();
    repeat (3) tick();
    checks++;
    if (start_cnt !== 0 || busy !== 1'b0 || disp_val !== RES_W'(1234)) begin
      errors++;
      $display("FAIL a_eq_ignored: starts=%0d busy=%b disp=%0d, expected 0/0/1234",
               start_cnt, busy, disp_val);
    end
    // a held key in S_OP must give one digit only
    opk(2'd1);
    key(1'b1, 1'b0, 1'b0, 4'd6, 2'd0, 15);
    checks++;
    if (alu_b !== W'(6) || disp_val !== RES_W'(6) || alu_op !== 2'd1) begin
      errors++;
      $display("FAIL hold_single: b=%0d disp=%0d op=%0d, expected 6/6/1", alu_b, disp_val, alu_op);
    end
  endtask

  task automatic test_alu_error();
    clr();
    dig(4'd8); opk(2'd3); dig(4'd0);
    cfg_lat = 2; cfg_res = RES_W'(123); cfg_err = 1'b1;
    eqk();
    repeat (6) tick();
    checks++;
    if (err !== 1'b1 || disp_val !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL div0_err: err=%b disp=%0d busy=%b, expected 1/0/0", err, disp_val, busy);
    end
    dig(4'd7); opk(2'd0);
    checks++;
    if (err !== 1'b1 || disp_val !== '0) begin
      errors++;
      $display("FAIL err_keys_ignored: err=%b disp=%0d, expected 1/0", err, disp_val);
    end
    clr();
    checks++;
    if (err !== 1'b0 || disp_val !== '0 || alu_a !== '0 || alu_b !== '0) begin
      errors++;
      $display("FAIL err_clear: err=%b disp=%0d a=%0d b=%0d, expected 0/0/0/0",
               err, disp_val, alu_a, alu_b);
    end
    dig(4'd7);
    checks++;
    if (disp_val !== RES_W'(7)) begin
      errors++;
      $display("FAIL after_clear_digit: disp=%0d, expected 7", disp_val);
    end
  endtask

  task automatic test_timeout();
    int err_k;
    clr();
    dig(4'd5); opk(2'd2); dig(4'd5);
    cfg_lat = 0; cfg_res = '0; cfg_err = 1'b0;
    is_eq = 1'b1;
    btn_press = 1'b1;
    tick();
    checks++;
    if (alu_start !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL to_start: start=%b busy=%b, expected 1/1", alu_start, busy);
    end
    btn_press = 1'b0;
    is_eq = 1'b0;
    err_k = 0;
    for (int k = 1; k <= 1100; k++) begin
      tick();
      if (k == 100) btn_press = 1'b1;
      if (k == 102) btn_press = 1'b0;
      if (k == 110) begin
        checks++;
        if (busy !== 1'b1 || err !== 1'b0 || alu_a !== W'(5) || alu_b !== W'(5)) begin
          errors++;
          $display("FAIL to_key_dropped: busy=%b err=%b a=%0d b=%0d, expected 1/0/5/5",
                   busy, err, alu_a, alu_b);
        end
      end
      if (err === 1'b1) begin
        err_k = k;
        break;
      end
    end
    checks++;
    if (err_k !== int'(TIMEOUT)) begin
      errors++;
      $display("FAIL to_latency: err after %0d cycles, expected %0d", err_k, TIMEOUT);
    end
    checks++;
    if (disp_val !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL to_state: disp=%0d busy=%b, expected 0/0", disp_val, busy);
    end
  endtask

  task automatic test_chain();
    logic [RES_W-1:0] neg5;
    neg5 = -28'sd5;
    clr();
    dig(4'd1); dig(4'd2); opk(2'd0); dig(4'd3);
    cfg_lat = 3; cfg_res = RES_W'(15); cfg_err = 1'b0;
    eqk();
    repeat (8) tick();
    opk(2'd1);
    checks++;
    if (alu_a !== W'(15) || alu_op !== 2'd1 || disp_val !== RES_W'(15)) begin
      errors++;
      $display("FAIL chain_latch: a=%0d op=%0d disp=%0d, expected 15/1/15", alu_a, alu_op, disp_val);
    end
    dig(4'd2); dig(4'd0);
    checks++;
    if (alu_b !== W'(20) || disp_val !== RES_W'(20)) begin
      errors++;
      $display("FAIL chain_b: b=%0d disp=%0d, expected 20/20", alu_b, disp_val);
    end
    cfg_res = neg5;
    eqk();
    repeat (8) tick();
    checks++;
    if (cap_a !== W'(15) || cap_b !== W'(20) || cap_op !== 2'd1 || disp_val !== neg5) begin
      errors++;
      $display("FAIL chain_result: a=%0d b=%0d op=%0d disp=%h, expected 15/20/1/%h",
               cap_a, cap_b, cap_op, disp_val, neg5);
    end
    opk(2'd0);
    checks++;
    if (err !== 1'b1 || disp_val !== '0) begin
      errors++;
      $display("FAIL chain_negative: err=%b disp=%0d, expected 1/0", err, disp_val);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    start_cnt = 0; busy_cnt = 0;
    cfg_lat = 0; cfg_res = '0; cfg_err = 1'b0;
    cap_a = '0; cap_b = '0; cap_op = '0;
    btn_press = 1'b0; is_num = 1'b0; is_op = 1'b0; is_eq = 1'b0;
    num_val = '0; op_val = '0;
    rst_n = 1'b0;
    test_reset();
    test_basic_add();
    test_digit_limit();
    test_alu_error();
    test_timeout();
    test_chain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_ctrl_fsm.md
Name: calc_ctrl_fsm

Overview:
- Sequencing controller for the calculator, driven by the keyboard decoder's event outputs (btn_press, is_num/is_op/is_eq, num_val, op_val).
- Builds operand A and operand B from decimal key entry and latches the operator.
- On "=" it issues a start/done transaction to the arithmetic unit, then holds the result or an error code for the display path.
- Runs in the keyboard clock domain (low-frequency internal oscillator).

Parameters:
DIGITS, 4, max decimal digits per operand
W, 14, operand width; must hold 10^DIGITS-1
RES_W, 28, signed result width
TIMEOUT, 1023, max cycles to wait for alu_done before error

Ports:
clk  in  1  system clock (keyboard clock domain)
rst_n  in  1  asynchronous active-low reset
btn_press  in  1  high while a key is held; decoded fields stable while high
is_num  in  1  pressed key is a digit
is_op  in  1  pressed key is an operator
is_eq  in  1  pressed key is "="
num_val  in  4  digit value 0..9
op_val  in  2  00 add, 01 sub, 10 mul, 11 div
alu_a  out  W  operand A to ALU
alu_b  out  W  operand B to ALU
alu_op  out  2  latched operator
alu_start  out  1  one-cycle start pulse
alu_done  in  1  ALU result valid (one-cycle pulse)
alu_result  in  RES_W  signed result
alu_err  in  1  ALU error (e.g. divide by zero); qualified by alu_done
disp_val  out  RES_W  signed value to display
err  out  1  error indicator
busy  out  1  high in S_EXEC

Behaviour:
Key events:
- key_evt = btn_press & ~btn_q, where btn_q is btn_press registered. A held key yields exactly one event.
- Decoded fields are sampled in the key_evt cycle.
- If none of is_num/is_op/is_eq is set, the key is CLEAR.
- All state and register updates occur at the key_evt clock edge, so outputs reflect the key one cycle later.
- CLEAR from any state except S_EXEC sets a=b=0, cnt=0, err=0, disp_val=0, and moves to S_A.

Reset (rst_n low, asynchronous):
- State S_A; a, b, cnt, op = 0; alu_start = 0; busy = 0; err = 0; disp_val = 0; btn_q = 0.
- Reset mid-S_EXEC abandons the transaction; alu_done arriving afterwards is ignored.

Digit append:
- x = x*10 + d, computed as (x<<3)+(x<<1)+d.
- Allowed only while cnt < DIGITS; otherwise the digit is ignored and the value is unchanged.

States:
- S_A: digit appends to a, cnt++, disp=a. Op latches op, sets cnt=0 -> S_OP. "=" is ignored.
- S_OP: digit sets b=d, cnt=1 -> S_B, disp=b. Op replaces the latched op. "=" is ignored.
- S_B: digit appends to b, disp=b. "=" -> S_EXEC. Op is ignored.
- S_EXEC:
  - alu_start is high for exactly the first cycle in the state; alu_a/alu_b/alu_op are held stable for the whole state.
  - alu_done is accepted in any S_EXEC cycle after the start cycle.
  - On done with alu_err=0: disp=alu_result -> S_RES.
  - On done with alu_err=1: err=1, disp=0 -> S_ERR.
  - A wait counter starts at 0 after start; when it reaches TIMEOUT with no done: err=1, disp=0 -> S_ERR.
  - All key events, including CLEAR, are discarded.
- S_RES:
  - Digit: a=d, cnt=1, b=0 -> S_A (new calculation).
  - Op (chaining):
    - If 0 <= result <= 10^DIGITS-1: a=result[W-1:0], op latched, cnt=0 -> S_OP, disp unchanged.
    - Otherwise: err=1, disp=0 -> S_ERR.
  - "=" is ignored.
- S_ERR: only CLEAR exits; digits, ops and "=" are ignored.

Other rules:
- alu_a/alu_b continuously drive the a/b registers.
- disp_val is sign-extended from W when showing an operand.
- A simultaneous key_evt and alu_done in S_EXEC: done is processed and the key is dropped.

Test Plan:
1. Reset: hold rst_n=0 with random inputs -> disp_val=0, err=0, busy=0, alu_start=0; first key after release is processed.
2. Keys 1,2,+,3,= with ALU model responding 3 cycles after start with result 15 -> exactly one alu_start pulse with alu_a=12, alu_b=3, alu_op=00; busy high 4 cycles; then disp_val=15.
3. Keys 1,2,3,4,5 with "5" held 20 cycles -> disp_val=1234 (5th digit ignored, single event per hold).
4. Keys 8, /(11), 0, = with ALU answering done with alu_err=1 -> err=1, disp_val=0; keys 7,+ ignored; CLEAR -> err=0, disp_val=0, next digit 7 gives disp_val=7.
5. Keys 5,*,5,= with alu_done never asserted -> err=1 exactly TIMEOUT cycles after the start cycle; a key pressed during the wait has no effect.
6. Chain: after result 15, keys -,20,= (ALU gives -5) -> alu_a=15, alu_b=20, disp=-5; then key + -> err=1 (negative result cannot chain).
